// File: rtl/pma_region_scanner.sv
// Iterative PMA region lookup: scans the non-idempotent, execute and cached rule tables
// RULES_PER_CYCLE rules per table per cycle. Optional macro PMA_SCAN_EARLY_EXIT_EN.
package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef logic [NrMaxRules-1:0][63:0] rule_tbl_t;

  typedef struct packed {
    int unsigned NrNonIdempotentRules;
    rule_tbl_t   NonIdempotentAddrBase;
    rule_tbl_t   NonIdempotentLength;
    int unsigned NrExecuteRegionRules;
    rule_tbl_t   ExecuteRegionAddrBase;
    rule_tbl_t   ExecuteRegionLength;
    int unsigned NrCachedRegionRules;
    rule_tbl_t   CachedRegionAddrBase;
    rule_tbl_t   CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module pma_region_scanner #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned RULES_PER_CYCLE = 4,
  parameter int unsigned IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [63:0]        req_addr_i,
  input  logic [IdWidth-1:0] req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [IdWidth-1:0] rsp_id_o,
  output logic               rsp_nonidem_o,
  output logic               rsp_exec_o,
  output logic               rsp_cached_o,
  output logic               busy_o
);

  localparam int unsigned NrNi = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned NrEx = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned NrCa = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned MaxA = (NrNi > NrEx) ? NrNi : NrEx;
  localparam int unsigned MaxRules = (MaxA > NrCa) ? MaxA : NrCa;
  localparam int unsigned NumChunks =
    (MaxRules == 0) ? 1 : (MaxRules + RULES_PER_CYCLE - 1) / RULES_PER_CYCLE;
  localparam int unsigned ChunkW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  state_e             state;
  logic [63:0]        addr_q;
  logic [IdWidth-1:0] id_q;
  logic [ChunkW-1:0]  chunk_q;
  logic               acc_ni, acc_ex, acc_ca;
  logic               nxt_ni, nxt_ex, nxt_ca;
  logic               last_chunk;
  logic               scan_done;

  // Hit test over one chunk of a table; the 65-bit limit avoids wrap at the top of memory.
  function automatic logic chunk_hit(input logic [63:0] addr,
                                     input config_pkg::rule_tbl_t base,
                                     input config_pkg::rule_tbl_t len,
                                     input int unsigned nr,
                                     input logic [ChunkW-1:0] chunk);
    int unsigned first;
    int unsigned idx;
    logic        hit;
    logic [3:0]  sel;
    hit   = 1'b0;
    first = 32'(chunk) * RULES_PER_CYCLE;
    for (int unsigned i = 0; i < RULES_PER_CYCLE; i++) begin
      idx = first + i;
      sel = idx[3:0];
      if ((idx < nr) && (idx < config_pkg::NrMaxRules)) begin
        if (({1'b0, addr} >= {1'b0, base[sel]}) &&
            ({1'b0, addr} < ({1'b0, base[sel]} + {1'b0, len[sel]})))
          hit = 1'b1;
      end
    end
    return hit;
  endfunction

  always_comb begin
    nxt_ni = acc_ni | chunk_hit(addr_q, CVA6Cfg.NonIdempotentAddrBase,
                                CVA6Cfg.NonIdempotentLength, NrNi, chunk_q);
    nxt_ex = acc_ex | chunk_hit(addr_q, CVA6Cfg.ExecuteRegionAddrBase,
                                CVA6Cfg.ExecuteRegionLength, NrEx, chunk_q);
    nxt_ca = acc_ca | chunk_hit(addr_q, CVA6Cfg.CachedRegionAddrBase,
                                CVA6Cfg.CachedRegionLength, NrCa, chunk_q);
  end

  assign last_chunk = (chunk_q == LastChunk);

`ifdef PMA_SCAN_EARLY_EXIT_EN
  // All three flags are already set, so further chunks cannot change the answer.
  assign scan_done = last_chunk || (nxt_ni && nxt_ex && nxt_ca);
`else
  assign scan_done = last_chunk;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      addr_q      <= '0;
      id_q        <= '0;
      chunk_q     <= '0;
      acc_ni      <= 1'b0;
      acc_ex      <= 1'b0;
      acc_ca      <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      chunk_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            addr_q      <= req_addr_i;
            id_q        <= req_id_i;
            chunk_q     <= '0;
            acc_ni      <= 1'b0;
            acc_ex      <= 1'b0;
            acc_ca      <= 1'b0;
            state       <= SCAN;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        SCAN: begin
          acc_ni  <= nxt_ni;
          acc_ex  <= nxt_ex;
          acc_ca  <= nxt_ca;
          chunk_q <= chunk_q + ChunkW'(1);
          if (scan_done) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_id_o      = id_q;
  assign rsp_nonidem_o = acc_ni;
  assign rsp_exec_o    = acc_ex;
  assign rsp_cached_o  = acc_ca;

endmodule
